// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states,
// opcode[6:2] classes and the datapath select encodings.
package cu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [4:0] OP_R       = 5'b01100;
  localparam logic [4:0] OP_I_ARITH = 5'b00100;
  localparam logic [4:0] OP_LOAD    = 5'b00000;
  localparam logic [4:0] OP_STORE   = 5'b01000;
  localparam logic [4:0] OP_BRANCH  = 5'b11000;
  localparam logic [4:0] OP_JAL     = 5'b11011;
  localparam logic [4:0] OP_JALR    = 5'b11001;
  localparam logic [4:0] OP_LUI     = 5'b01101;
  localparam logic [4:0] OP_AUIPC   = 5'b00101;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Known opcode with a funct3 that is defined for its class.
  function automatic logic insn_legal(input logic [4:0] op, input logic [2:0] f3);
    logic ok;
    case (op)
      OP_R, OP_I_ARITH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: ok = 1'b1;
      OP_LOAD:   ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      OP_STORE:  ok = (f3 <= 3'b010);
      OP_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cu_alu_decode.sv
// Combinational ALU/operand control from the latched opcode class, funct3
// and inst[30]; shared by every state that needs the ALU driven.
module cu_alu_decode
  import cu_pkg::*;
(
  input  logic [4:0] op,
  input  logic [2:0] funct3,
  input  logic       inst30,
  output logic [3:0] alu_sel,
  output logic [2:0] imm_sel,
  output logic       a_sel,
  output logic       b_sel
);

  logic [3:0] arith_sel;

  always_comb begin
    case (funct3)
      3'b000:  arith_sel = ALU_ADD;
      3'b001:  arith_sel = ALU_SLL;
      3'b010:  arith_sel = ALU_SLT;
      3'b011:  arith_sel = ALU_SLTU;
      3'b100:  arith_sel = ALU_XOR;
      3'b101:  arith_sel = inst30 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_sel = ALU_OR;
      default: arith_sel = ALU_AND;
    endcase
  end

  always_comb begin
    alu_sel = ALU_ADD;
    imm_sel = IMM_I;
    a_sel   = 1'b0;
    b_sel   = 1'b0;
    case (op)
      // inst[30] means SUB only for register-register funct3=000
      OP_R:       alu_sel = ((funct3 == 3'b000) && inst30) ? ALU_SUB : arith_sel;
      OP_I_ARITH: begin alu_sel = arith_sel; b_sel = 1'b1; end
      OP_LOAD:    b_sel = 1'b1;
      OP_STORE:   begin b_sel = 1'b1; imm_sel = IMM_S; end
      OP_LUI:     begin alu_sel = ALU_PASS_B; b_sel = 1'b1; imm_sel = IMM_U; end
      OP_AUIPC:   begin a_sel = 1'b1; b_sel = 1'b1; imm_sel = IMM_U; end
      OP_BRANCH:  begin a_sel = 1'b1; b_sel = 1'b1; imm_sel = IMM_B; end
      OP_JAL:     begin a_sel = 1'b1; b_sel = 1'b1; imm_sel = IMM_J; end
      OP_JALR:    b_sel = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB) with imem/dmem
// ready handshakes. Optional CU_ILLEGAL_TRAP_EN adds a sticky TRAP state.
//
// Handshake: imem_req/dmem_req stay high until the matching *_ready is seen
// high in the same cycle; that cycle completes the transfer. A request may be
// abandoned by reset at any time.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int ALUSEL_W         = 4,
  parameter int IMMSEL_W         = 3,
  parameter int WBSEL_W          = 2,
  parameter int RESET_STATE_HOLD = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         inst,
  input  logic                BrEq,
  input  logic                BrLt,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                PCSel,
  output logic                RegWEn,
  output logic                BrUn,
  output logic                ASel,
  output logic                BSel,
  output logic                MemRW,
  output logic [WBSEL_W-1:0]  WBSel,
  output logic [IMMSEL_W-1:0] ImmSel,
  output logic [ALUSEL_W-1:0] ALUSel,
  output logic                retire,
`ifdef CU_ILLEGAL_TRAP_EN
  output logic                illegal,
`endif
  output logic [2:0]          state_dbg
);

  localparam int HOLD_W = (RESET_STATE_HOLD > 0) ? $clog2(RESET_STATE_HOLD + 1) : 1;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [4:0]        op_q, op_d;
  logic [2:0]        f3_q, f3_d;
  logic              b30_q, b30_d;

  logic [3:0] alu_sel;
  logic [2:0] imm_sel;
  logic       a_sel, b_sel, alu_on, br_taken;
  logic       unused_inst_bits;

  assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7], inst[1:0]};
  assign state_dbg        = state_q;

  cu_alu_decode u_alu_decode (
    .op      (op_q),
    .funct3  (f3_q),
    .inst30  (b30_q),
    .alu_sel (alu_sel),
    .imm_sel (imm_sel),
    .a_sel   (a_sel),
    .b_sel   (b_sel)
  );

  always_comb begin
    case (f3_q)
      3'b000:         br_taken = BrEq;
      3'b001:         br_taken = !BrEq;
      3'b100, 3'b110: br_taken = BrLt;
      3'b101, 3'b111: br_taken = !BrLt;
      default:        br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      hold_q  <= HOLD_W'(RESET_STATE_HOLD);
      op_q    <= '0;
      f3_q    <= '0;
      b30_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      op_q    <= op_d;
      f3_q    <= f3_d;
      b30_q   <= b30_d;
    end
  end

  // Everything is forced low while rst is high so requests drop at once.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    op_d     = op_q;
    f3_d     = f3_q;
    b30_d    = b30_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSel    = 1'b0;
    RegWEn   = 1'b0;
    BrUn     = 1'b0;
    MemRW    = 1'b0;
    WBSel    = '0;
    retire   = 1'b0;
    alu_on   = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
    illegal  = 1'b0;
`endif
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
          end else begin
            imem_req = 1'b1;
            if (imem_ready) begin
              IRWrite = 1'b1;
              PCWrite = 1'b1;
              state_d = S_DECODE;
            end
          end
        end
        S_DECODE: begin
          op_d  = inst[6:2];
          f3_d  = inst[14:12];
          b30_d = inst[30];
          if (insn_legal(inst[6:2], inst[14:12])) begin
            state_d = S_EXEC;
          end else begin
`ifdef CU_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            retire  = 1'b1;
            state_d = S_FETCH;
`endif
          end
        end
        S_EXEC: begin
          alu_on = 1'b1;
          case (op_q)
            OP_BRANCH: begin
              BrUn    = f3_q[1];
              PCSel   = 1'b1;
              PCWrite = br_taken;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            OP_JAL, OP_JALR: begin
              PCSel   = 1'b1;
              PCWrite = 1'b1;
              state_d = S_WB;
            end
            OP_LOAD, OP_STORE: state_d = S_MEM;
            default:           state_d = S_WB;
          endcase
        end
        S_MEM: begin
          alu_on   = 1'b1;
          dmem_req = 1'b1;
          MemRW    = (op_q == OP_STORE);
          if (dmem_ready) begin
            retire  = (op_q == OP_STORE);
            state_d = (op_q == OP_STORE) ? S_FETCH : S_WB;
          end
        end
        S_WB: begin
          // ALU controls stay up: rd takes the live ALU result when WBSel=ALU
          alu_on  = 1'b1;
          RegWEn  = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
          if (op_q == OP_LOAD)                         WBSel = WBSEL_W'(WB_MEM);
          else if ((op_q == OP_JAL) || (op_q == OP_JALR)) WBSel = WBSEL_W'(WB_PC4);
          else                                         WBSel = WBSEL_W'(WB_ALU);
        end
        S_TRAP: begin
`ifdef CU_ILLEGAL_TRAP_EN
          illegal = 1'b1;
`else
          state_d = S_FETCH;
`endif
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign ALUSel = alu_on ? ALUSEL_W'(alu_sel) : '0;
  assign ImmSel = alu_on ? IMMSEL_W'(imm_sel) : '0;
  assign ASel   = alu_on & a_sel;
  assign BSel   = alu_on & b_sel;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-cycle expected control words built from the
// instruction-level rules, driven with random memory latencies.
module tb_multicycle_control_unit;

  localparam int HOLD = 2;

  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4;
  localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_BAD = 9;

  localparam logic [4:0] OPS [9] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000,
                                     5'b11000, 5'b11011, 5'b11001, 5'b01101, 5'b00101};
  localparam logic [4:0] BAD_OPS [6] = '{5'b00001, 5'b00011, 5'b00110,
                                         5'b01011, 5'b10100, 5'b11111};
  localparam int ALU_OF_F3 [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       irw;
    logic       pcw;
    logic       pcs;
    logic       regw;
    logic       brun;
    logic       asel;
    logic       bsel;
    logic       memrw;
    logic [1:0] wbs;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       ret;
    logic       ill;
  } outv_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = '0;
  logic        BrEq = 1'b0, BrLt = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic        imem_req, dmem_req, IRWrite, PCWrite, PCSel, RegWEn, BrUn;
  logic        ASel, BSel, MemRW, retire, ill_w;
  logic [1:0]  WBSel;
  logic [2:0]  ImmSel;
  logic [3:0]  ALUSel;
  logic [2:0]  state_dbg_unused;
  logic [20:0] obs;

  logic [20:0] exp_q[$];
  logic [35:0] stim_q[$];
  string       tag_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] cur_inst = 32'h0000_0013;
  logic        trap_pending = 1'b0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.RESET_STATE_HOLD(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst),
    .BrEq       (BrEq),
    .BrLt       (BrLt),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCSel      (PCSel),
    .RegWEn     (RegWEn),
    .BrUn       (BrUn),
    .ASel       (ASel),
    .BSel       (BSel),
    .MemRW      (MemRW),
    .WBSel      (WBSel),
    .ImmSel     (ImmSel),
    .ALUSel     (ALUSel),
    .retire     (retire),
`ifdef CU_ILLEGAL_TRAP_EN
    .illegal    (ill_w),
`endif
    .state_dbg  (state_dbg_unused)
  );

`ifndef CU_ILLEGAL_TRAP_EN
  assign ill_w = 1'b0;
`endif

  assign obs = {imem_req, dmem_req, IRWrite, PCWrite, PCSel, RegWEn, BrUn, ASel,
                BSel, MemRW, WBSel, ImmSel, ALUSel, retire, ill_w};

  task automatic check_eq(input string tag, input logic [20:0] got, input logic [20:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%06h want=%06h (inst=%08h)", tag, $time, got, want, inst);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int classify(input logic [31:0] w);
    int c;
    c = C_BAD;
    for (int k = 0; k < 9; k++) if (w[6:2] == OPS[k]) c = k;
    case (c)
      C_LD:    if (w[14:12] inside {3'd3, 3'd6, 3'd7}) c = C_BAD;
      C_ST:    if (w[14:12] > 3'd2) c = C_BAD;
      C_BR:    if (w[14:12] inside {3'd2, 3'd3}) c = C_BAD;
      default: ;
    endcase
    return c;
  endfunction

  function automatic outv_t alu_ctl(input logic [31:0] w, input int c);
    outv_t      e;
    logic [2:0] f3;
    int         a;
    e  = '0;
    f3 = w[14:12];
    a  = ALU_OF_F3[f3];
    if (f3 == 3'd5 && w[30]) a = 7;
    case (c)
      C_R:     begin if (f3 == 3'd0 && w[30]) a = 1; e.alu = 4'(a); end
      C_I:     begin e.alu = 4'(a); e.bsel = 1'b1; end
      C_LD:    e.bsel = 1'b1;
      C_ST:    begin e.bsel = 1'b1; e.imm = 3'd1; end
      C_BR:    begin e.asel = 1'b1; e.bsel = 1'b1; e.imm = 3'd2; end
      C_JAL:   begin e.asel = 1'b1; e.bsel = 1'b1; e.imm = 3'd4; end
      C_JALR:  e.bsel = 1'b1;
      C_LUI:   begin e.alu = 4'd10; e.bsel = 1'b1; e.imm = 3'd3; end
      C_AUIPC: begin e.asel = 1'b1; e.bsel = 1'b1; e.imm = 3'd3; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic be, input logic bl);
    case (f3)
      3'd0:       return be;
      3'd1:       return !be;
      3'd4, 3'd6: return bl;
      3'd5, 3'd7: return !bl;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic push(input string tag, input logic [31:0] w, input logic ir, input logic dr,
                      input logic be, input logic bl, input outv_t e);
    tag_q.push_back(tag);
    stim_q.push_back({w, ir, dr, be, bl});
    exp_q.push_back(e);
  endtask

  task automatic push_idle();
    for (int k = 0; k < HOLD; k++) push("hold", cur_inst, rb(), rb(), rb(), rb(), '0);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction.
  task automatic model_insn(input logic [31:0] w, input int wi, input int wd,
                            input logic be, input logic bl);
    outv_t e, a;
    int    c;
    c = classify(w);
    a = alu_ctl(w, c);
    for (int k = 0; k < wi; k++) begin
      e = '0; e.imem_req = 1'b1;
      push("fetch_wait", cur_inst, 1'b0, rb(), rb(), rb(), e);
    end
    e = '0; e.imem_req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    push("fetch", cur_inst, 1'b1, rb(), rb(), rb(), e);
    cur_inst = w;
    e = '0;
    if (c == C_BAD) begin
`ifdef CU_ILLEGAL_TRAP_EN
      push("decode_bad", w, rb(), rb(), rb(), rb(), e);
      e.ill = 1'b1;
      for (int k = 0; k < 3; k++) push("trap", w, rb(), rb(), rb(), rb(), e);
      trap_pending = 1'b1;
`else
      e.ret = 1'b1;
      push("decode_nop", w, rb(), rb(), rb(), rb(), e);
`endif
      return;
    end
    push("decode", w, rb(), rb(), rb(), rb(), e);
    e = a;
    if (c == C_BR) begin
      e.brun = w[13]; e.pcs = 1'b1; e.ret = 1'b1; e.pcw = taken(w[14:12], be, bl);
      push("exec_br", w, rb(), rb(), be, bl, e);
      return;
    end
    if (c == C_JAL || c == C_JALR) begin e.pcw = 1'b1; e.pcs = 1'b1; end
    push("exec", w, rb(), rb(), be, bl, e);
    if (c == C_LD || c == C_ST) begin
      e = a; e.dmem_req = 1'b1; e.memrw = (c == C_ST);
      for (int k = 0; k < wd; k++) push("mem_wait", w, rb(), 1'b0, rb(), rb(), e);
      e.ret = (c == C_ST);
      push("mem", w, rb(), 1'b1, rb(), rb(), e);
      if (c == C_ST) return;
    end
    e = a; e.regw = 1'b1; e.ret = 1'b1;
    e.wbs = (c == C_LD) ? 2'd0 : ((c == C_JAL || c == C_JALR) ? 2'd2 : 2'd1);
    push("wb", w, rb(), rb(), rb(), rb(), e);
  endtask

  task automatic run_n(input int n);
    logic [35:0] s;
    logic [20:0] want;
    string       t;
    for (int k = 0; k < n; k++) begin
      s    = stim_q.pop_front();
      t    = tag_q.pop_front();
      want = exp_q.pop_front();
      @(negedge clk);
      {inst, imem_ready, dmem_ready, BrEq, BrLt} = s;
      #1 check_eq(t, obs, want);
    end
  endtask

  task automatic run_q();
    run_n(exp_q.size());
  endtask

  // Asynchronous reset mid-cycle, then release just after a rising edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_eq("rst_async", obs, '0);
    @(posedge clk);
    @(negedge clk);
    #1 check_eq("rst_held", obs, '0);
    @(posedge clk);
    #2 rst = 1'b0;
    push_idle();
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    int          c;
    w = $urandom();
    c = $urandom_range(0, 9);
    if (c < 9) w[6:2] = OPS[c];
    else       w[6:2] = BAD_OPS[$urandom_range(0, 5)];
    w[1:0] = 2'b11;
    return w;
  endfunction

  initial begin
    @(negedge clk);
    #1 check_eq("reset", obs, '0);
    @(posedge clk);
    #2 rst = 1'b0;
    push_idle();

    model_insn(32'h0050_0093, 0, 0, 1'b0, 1'b0);  // addi x1,x0,5
    model_insn(32'h0000_A103, 0, 3, 1'b0, 1'b0);  // lw x2,0(x1)
    model_insn(32'h0000_0463, 0, 0, 1'b1, 1'b0);  // beq taken
    model_insn(32'h0000_0463, 0, 0, 1'b0, 1'b1);  // beq not taken
    model_insn(32'h0020_2223, 0, 0, 1'b0, 1'b0);  // sw x2,4(x0)
    model_insn(32'h1234_51B7, 0, 0, 1'b0, 1'b0);  // lui x3,0x12345
    model_insn(32'h0000_00EF, 0, 0, 1'b0, 1'b0);  // jal x1,0
    model_insn(32'h4030_80B3, 2, 0, 1'b0, 1'b0);  // sub x1,x1,x3
    model_insn(32'h4050_D093, 0, 0, 1'b0, 1'b0);  // srai x1,x1,5
    run_q();

    for (int n = 0; n < 120; n++) begin
      model_insn(rand_insn(),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0,
                 rb(), rb());
      run_q();
      if (trap_pending) begin
        trap_pending = 1'b0;
        do_reset();
      end
    end

    // Abandon a load in the middle of its data access.
    model_insn(32'h0000_A103, 0, 6, 1'b0, 1'b0);
    run_n(5);
    exp_q.delete();
    stim_q.delete();
    tag_q.delete();
    do_reset();
    model_insn(32'h0050_0093, 1, 0, 1'b0, 1'b0);
    run_q();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
